// File: rtl/dac_spi_pkg.sv
//==============================================================================
// Module      : dac_spi_pkg
// Description : Shared types and constants for the 12-bit, 4-channel DAC
//               serial writer (state encoding, frame width, mode bits).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dac_spi_pkg;

    // Writer sequencing: accept -> CS setup -> 16 SCLK periods -> CS hold -> gap
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int         FRAME_W       = 16;
    localparam logic [1:0] DEF_MODE_BITS = 2'b01;

    // Frame layout as seen by the DAC, MSB shifted first
    function automatic logic [FRAME_W-1:0] make_frame(
        input logic [1:0]  chan,
        input logic [1:0]  mode,
        input logic [11:0] code
    );
        return {chan, mode, code};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_sclk_tick.sv
//==============================================================================
// Module      : dac_sclk_tick
// Description : SCLK half-period timer. Emits a one-cycle tick every CLK_DIV
//               enabled cycles; restart zeroes the count so every timed state
//               starts from a full half-period.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dac_sclk_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    // Count enabled cycles, wrapping on the tick so SHIFT toggles continuously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (restart) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_spi_writer.sv
//==============================================================================
// Module      : dac_spi_writer
// Description : Valid/ready fed SPI mode-0 writer for a 12-bit 4-channel DAC.
//               One 16-bit frame {chan, mode, code} per accepted code, MSB
//               first, followed by a minimum CS_N-high gap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dac_spi_writer
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV   = 25,
    parameter int         CS_GAP    = 50,
    parameter logic [1:0] MODE_BITS = DEF_MODE_BITS
) (
    input  logic        Sys_CLK,
    input  logic        Sys_RST,
    input  logic [11:0] Data_In,
    input  logic [1:0]  Chan_In,
    input  logic        Data_Valid,
    output logic        Data_Ready,
    output logic        DA_SCLK,
    output logic        DA_CS_N,
    output logic        DA_SDI,
    output logic        Busy,
    output logic        Done
);

    // Gap counter only has to reach CS_GAP-1
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t               state;
    logic [FRAME_W-1:0]   shreg;
    logic [4:0]           bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 accept;
    logic                 tick;
    logic                 tick_en;
    logic                 tick_restart;
    logic                 last_low;

    assign accept   = Data_Valid && Data_Ready;
    assign tick_en  = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    // Low phase following the final falling edge: next tick leaves SHIFT
    assign last_low = (state == SHIFT) && !DA_SCLK && (bit_cnt == 5'(FRAME_W));
    assign tick_restart = accept || (tick && ((state == SETUP) || last_low));

    dac_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (Sys_CLK),
        .rst_n   (Sys_RST),
        .en      (tick_en),
        .restart (tick_restart),
        .tick    (tick)
    );

    // Frame sequencer; every pin and status output is driven from here
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= 5'd0;
            gap_cnt    <= '0;
            Data_Ready <= 1'b1;
            DA_SCLK    <= 1'b0;
            DA_CS_N    <= 1'b1;
            DA_SDI     <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= make_frame(Chan_In, MODE_BITS, Data_In);
                        bit_cnt    <= 5'd0;
                        Data_Ready <= 1'b0;
                        Busy       <= 1'b1;
                        DA_CS_N    <= 1'b0;
                        DA_SDI     <= Chan_In[1];
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        DA_SCLK <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (DA_SCLK) begin
                            // Falling edge: advance to the next bit while SCLK is low
                            DA_SCLK <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= shreg << 1;
                            DA_SDI  <= shreg[FRAME_W-2];
                        end else if (bit_cnt == 5'(FRAME_W)) begin
                            state <= HOLD;
                        end else begin
                            DA_SCLK <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        DA_CS_N <= 1'b1;
                        DA_SDI  <= 1'b0;
                        Done    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // The Done cycle is the first of the CS_GAP gap cycles
                    if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        Data_Ready <= 1'b1;
                        Busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_writer.sv
//==============================================================================
// Module      : tb_dac_spi_writer
// Description : Scoreboard bench for dac_spi_writer: default instance plus a
//               fast (CLK_DIV=2, CS_GAP=1) instance on a shared clock/reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dac_spi_writer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // default instance
    logic [11:0] d_data  = 12'h0;
    logic [1:0]  d_chan  = 2'b0;
    logic        d_valid = 1'b0;
    logic        d_ready, d_sclk, d_csn, d_sdi, d_busy, d_done;

    // fast instance
    logic [11:0] f_data  = 12'h0;
    logic [1:0]  f_chan  = 2'b0;
    logic        f_valid = 1'b0;
    logic        f_ready, f_sclk, f_csn, f_sdi, f_busy, f_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // scoreboard queues: expected (pushed at accept) and received (pushed at Done)
    logic [15:0] exp_q[$];
    logic [15:0] rx_q0[$];
    logic [15:0] exp_fq[$];
    logic [15:0] rx_q1[$];

    // monitor state, index 0 = default instance, 1 = fast instance
    logic [1:0]  sclk_v, sdi_v, csn_v, done_v;
    logic [15:0] rx_sh[2];
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        prev_sdi[2]  = '{1'b0, 1'b0};
    logic        prev_csn[2]  = '{1'b1, 1'b1};
    int          rx_bits[2]      = '{0, 0};
    int          rise_cnt[2]     = '{0, 0};
    int          done_cnt[2]     = '{0, 0};
    int          low_cnt[2]      = '{0, 0};
    int          proto_err[2]    = '{0, 0};
    int          last_rise[2]    = '{0, 0};
    int          rise_period[2]  = '{0, 0};
    int          csn_rise_cyc[2] = '{0, 0};

    assign sclk_v = {f_sclk, d_sclk};
    assign sdi_v  = {f_sdi,  d_sdi};
    assign csn_v  = {f_csn,  d_csn};
    assign done_v = {f_done, d_done};

    dac_spi_writer u_dut (
        .Sys_CLK    (clk),
        .Sys_RST    (rst_n),
        .Data_In    (d_data),
        .Chan_In    (d_chan),
        .Data_Valid (d_valid),
        .Data_Ready (d_ready),
        .DA_SCLK    (d_sclk),
        .DA_CS_N    (d_csn),
        .DA_SDI     (d_sdi),
        .Busy       (d_busy),
        .Done       (d_done)
    );

    dac_spi_writer #(
        .CLK_DIV (2),
        .CS_GAP  (1)
    ) u_fast (
        .Sys_CLK    (clk),
        .Sys_RST    (rst_n),
        .Data_In    (f_data),
        .Chan_In    (f_chan),
        .Data_Valid (f_valid),
        .Data_Ready (f_ready),
        .DA_SCLK    (f_sclk),
        .DA_CS_N    (f_csn),
        .DA_SDI     (f_sdi),
        .Busy       (f_busy),
        .Done       (f_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // DAC-side model: shift SDI on SCLK rising edges, collect frames on Done,
    // and flag protocol violations (SDI moving while SCLK high, SCLK edges with CS_N high)
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rx_bits[i] = 0;
            end else begin
                if (sclk_v[i] && !prev_sclk[i]) begin
                    rx_sh[i] = {rx_sh[i][14:0], sdi_v[i]};
                    rx_bits[i]++;
                    rise_cnt[i]++;
                    if (rx_bits[i] > 1) rise_period[i] = cyc - last_rise[i];
                    last_rise[i] = cyc;
                end
                if (done_v[i]) begin
                    if (i == 0) rx_q0.push_back(rx_sh[i]);
                    else        rx_q1.push_back(rx_sh[i]);
                    done_cnt[i]++;
                    rx_bits[i] = 0;
                end
                if (!csn_v[i]) low_cnt[i]++;
                if (csn_v[i] && !prev_csn[i]) csn_rise_cyc[i] = cyc;
            end
            if (sclk_v[i] && (sdi_v[i] != prev_sdi[i])) proto_err[i]++;
            if ((sclk_v[i] != prev_sclk[i]) && csn_v[i] && prev_csn[i]) proto_err[i]++;
            prev_sclk[i] = sclk_v[i];
            prev_sdi[i]  = sdi_v[i];
            prev_csn[i]  = csn_v[i];
        end
    end

    // All stimulus and checks happen just after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_main_ready(input string name, output int at);
        int n = 0;
        while (d_ready !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        at = cyc;
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s: Data_Ready never returned within 3000 cycles", name);
        end
    endtask

    // Offer one code; returns the cycle in which it was accepted
    task automatic send_main(input logic [11:0] d, input logic [1:0] c,
                             input bit push, output int acc);
        d_data  = d;
        d_chan  = c;
        d_valid = 1'b1;
        wait_main_ready("send", acc);
        if (push) exp_q.push_back({c, 2'b01, d});
        low_cnt[0] = 0;
        step();
        d_valid = 1'b0;
    endtask

    task automatic check_main_frames(input string name);
        logic [15:0] e, r;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rx_q0.size() == 0) begin
                bad++;
                $display("FAIL %s: no frame received, required %h", name, e);
            end else begin
                r = rx_q0.pop_front();
                if (r !== e) begin
                    bad++;
                    $display("FAIL %s: frame got %h required %h", name, r, e);
                end
            end
        end
        total++;
        if (rx_q0.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d unexpected extra frame(s), first %h", name, rx_q0.size(), rx_q0[0]);
        end
        rx_q0.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        total++;
        if ({d_ready, d_sclk, d_csn, d_sdi, d_busy, d_done} !== 6'b101000) begin
            bad++;
            $display("FAIL reset_main: {rdy,sclk,csn,sdi,busy,done} got %b required 101000",
                     {d_ready, d_sclk, d_csn, d_sdi, d_busy, d_done});
        end
        total++;
        if ({f_ready, f_sclk, f_csn, f_sdi, f_busy, f_done} !== 6'b101000) begin
            bad++;
            $display("FAIL reset_fast: {rdy,sclk,csn,sdi,busy,done} got %b required 101000",
                     {f_ready, f_sclk, f_csn, f_sdi, f_busy, f_done});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int a, r, d0, r0;
        d0 = done_cnt[0];
        r0 = rise_cnt[0];
        send_main(12'hABC, 2'b10, 1'b1, a);
        total++;
        if ({d_busy, d_ready} !== 2'b10) begin
            bad++;
            $display("FAIL single_busy: {busy,ready} got %b required 10", {d_busy, d_ready});
        end
        wait_main_ready("single", r);
        total++;
        if (r - a !== 901) begin
            bad++;
            $display("FAIL single_latency: accept-to-ready got %0d required 901", r - a);
        end
        total++;
        if (low_cnt[0] !== 850) begin
            bad++;
            $display("FAIL single_cs_low: CS_N low cycles got %0d required 850", low_cnt[0]);
        end
        total++;
        if (done_cnt[0] - d0 !== 1) begin
            bad++;
            $display("FAIL single_done: Done pulses got %0d required 1", done_cnt[0] - d0);
        end
        total++;
        if (rise_cnt[0] - r0 !== 16) begin
            bad++;
            $display("FAIL single_rises: SCLK rising edges got %0d required 16", rise_cnt[0] - r0);
        end
        total++;
        if (d_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_end: Busy got %b required 0", d_busy);
        end
        check_main_frames("single_frame");
    endtask

    task automatic test_back_to_back();
        int a1, a2, r, gap, r0;
        r0 = rise_cnt[0];
        d_data  = 12'h000;
        d_chan  = 2'b11;
        d_valid = 1'b1;
        wait_main_ready("b2b_first", a1);
        exp_q.push_back(16'hD000);
        step();
        d_data = 12'hFFF;
        wait_main_ready("b2b_second", a2);
        exp_q.push_back(16'hDFFF);
        gap = a2 - csn_rise_cyc[0];
        step();
        d_valid = 1'b0;
        wait_main_ready("b2b_end", r);
        total++;
        if (gap !== 50) begin
            bad++;
            $display("FAIL b2b_gap: CS_N high gap got %0d required 50", gap);
        end
        total++;
        if (a2 - a1 !== 901) begin
            bad++;
            $display("FAIL b2b_period: accept spacing got %0d required 901", a2 - a1);
        end
        total++;
        if (rise_cnt[0] - r0 !== 32) begin
            bad++;
            $display("FAIL b2b_rises: SCLK rising edges got %0d required 32", rise_cnt[0] - r0);
        end
        check_main_frames("b2b_frame");
    endtask

    task automatic test_valid_noise();
        int a, r, d0, n;
        d0 = done_cnt[0];
        send_main(12'h123, 2'b01, 1'b1, a);
        n = 0;
        while (done_cnt[0] == d0 && n < 1500) begin
            d_valid = 1'($urandom_range(0, 1));
            d_data  = 12'($urandom);
            d_chan  = 2'($urandom);
            step();
            n++;
        end
        d_valid = 1'b0;
        wait_main_ready("noise", r);
        total++;
        if (done_cnt[0] - d0 !== 1) begin
            bad++;
            $display("FAIL noise_done: Done pulses got %0d required 1", done_cnt[0] - d0);
        end
        check_main_frames("noise_frame");
    endtask

    task automatic test_reset_mid_frame();
        int a, r, d0, r0, n;
        d0 = done_cnt[0];
        r0 = rise_cnt[0];
        send_main(12'h777, 2'b10, 1'b0, a);
        n = 0;
        while (rise_cnt[0] - r0 < 7 && n < 1000) begin
            step();
            n++;
        end
        total++;
        if (rise_cnt[0] - r0 !== 7) begin
            bad++;
            $display("FAIL midrst_reach: SCLK rises before reset got %0d required 7", rise_cnt[0] - r0);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({d_ready, d_sclk, d_csn, d_sdi, d_busy, d_done} !== 6'b101000) begin
            bad++;
            $display("FAIL midrst_async: {rdy,sclk,csn,sdi,busy,done} got %b required 101000",
                     {d_ready, d_sclk, d_csn, d_sdi, d_busy, d_done});
        end
        step(); step(); step();
        total++;
        if (done_cnt[0] - d0 !== 0) begin
            bad++;
            $display("FAIL midrst_done: Done pulses got %0d required 0", done_cnt[0] - d0);
        end
        rst_n = 1'b1;
        send_main(12'h456, 2'b01, 1'b1, a);
        total++;
        if (d_busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_first_accept: Busy after first edge got %b required 1", d_busy);
        end
        wait_main_ready("midrst", r);
        check_main_frames("midrst_frame");
    endtask

    task automatic test_fast();
        int a, n;
        logic [15:0] e, got;
        f_data  = 12'h5A5;
        f_chan  = 2'b00;
        f_valid = 1'b1;
        a = cyc;
        total++;
        if (f_ready !== 1'b1) begin
            bad++;
            $display("FAIL fast_ready: Data_Ready got %b required 1", f_ready);
        end
        exp_fq.push_back(16'h15A5);
        low_cnt[1] = 0;
        step();
        f_valid = 1'b0;
        n = 0;
        while (f_ready !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        total++;
        if (cyc - a !== 70) begin
            bad++;
            $display("FAIL fast_latency: accept-to-ready got %0d required 70", cyc - a);
        end
        total++;
        if (low_cnt[1] !== 68) begin
            bad++;
            $display("FAIL fast_cs_low: CS_N low cycles got %0d required 68", low_cnt[1]);
        end
        total++;
        if (rise_period[1] !== 4) begin
            bad++;
            $display("FAIL fast_period: SCLK period got %0d required 4", rise_period[1]);
        end
        e = exp_fq.pop_front();
        total++;
        if (rx_q1.size() != 1) begin
            bad++;
            $display("FAIL fast_frame: frames received got %0d required 1", rx_q1.size());
        end else begin
            got = rx_q1.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL fast_frame: frame got %h required %h", got, e);
            end
        end
    endtask

    task automatic test_protocol();
        total++;
        if (proto_err[0] + proto_err[1] !== 0) begin
            bad++;
            $display("FAIL protocol: violations got %0d (main) %0d (fast) required 0",
                     proto_err[0], proto_err[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_valid_noise();
        test_reset_mid_frame();
        test_fast();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
